// File: rtl/jericalla_pkg.sv
// Shared types and constants for the jericalla register-file/ALU datapath.
// Build option JERICALLA_SLL_EN turns opcode 111 from NOP into shift-left-logical.
package jericalla_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;
  localparam int SHAMT_W  = $clog2(DATA_W);
  localparam int INSTR_W  = 18;

  localparam int OP_MSB = 17;
  localparam int OP_LSB = 15;
  localparam int RS_MSB = 14;
  localparam int RS_LSB = 10;
  localparam int RT_MSB = 9;
  localparam int RT_LSB = 5;
  localparam int RD_MSB = 4;
  localparam int RD_LSB = 0;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_NOR = 3'b100,
    OP_XOR = 3'b101,
    OP_SLT = 3'b110,
`ifdef JERICALLA_SLL_EN
    OP_SLL = 3'b111
`else
    OP_NOP = 3'b111
`endif
  } op_e;

  typedef struct packed {
    op_e               op;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [ADDR_W-1:0] rd;
  } instr_t;

  function automatic instr_t decode_instr(input logic [INSTR_W-1:0] raw);
    instr_t d;
    d.op = op_e'(raw[OP_MSB:OP_LSB]);
    d.rs = raw[RS_MSB:RS_LSB];
    d.rt = raw[RT_MSB:RT_LSB];
    d.rd = raw[RD_MSB:RD_LSB];
    return d;
  endfunction

endpackage

// File: rtl/jericalla_if.sv
// Instruction-in / result-out bundle between the instruction source and the core.
interface jericalla_if;
  import jericalla_pkg::*;

  logic [INSTR_W-1:0] instruccion;
  logic               zf_jericalla;
  logic [DATA_W-1:0]  dataOut_jericalla;

  modport master (output instruccion, input  zf_jericalla, input  dataOut_jericalla);
  modport slave  (input  instruccion, output zf_jericalla, output dataOut_jericalla);
endinterface

// File: rtl/jericalla_alu.sv
// Combinational ALU: (op, a, b) -> result, modulo 2^DATA_W.
module jericalla_alu
  import jericalla_pkg::*;
(
  input  op_e               op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      OP_ADD: result_o = a_i + b_i;
      OP_SUB: result_o = a_i - b_i;
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_NOR: result_o = ~(a_i | b_i);
      OP_XOR: result_o = a_i ^ b_i;
      OP_SLT: result_o = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
`ifdef JERICALLA_SLL_EN
      OP_SLL: result_o = a_i << b_i[SHAMT_W-1:0];
`endif
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/jericalla_evo_core.sv
// Single-cycle datapath: 32x32 register file, ALU, registered result and zero flag.
// Build option JERICALLA_SLL_EN makes opcode 111 a shift-left instead of a NOP.
module jericalla_evo_core
  import jericalla_pkg::*;
(
  input logic        clk_jericalla,
  input logic        rst_n_jericalla,
  jericalla_if.slave bus
);

  instr_t            instr;
  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              zf_q, zf_d;
  logic              wr_en;

  assign instr = decode_instr(bus.instruccion);
  assign op_a  = rf_q[instr.rs];
  assign op_b  = rf_q[instr.rt];

  jericalla_alu u_alu (
    .op_i     (instr.op),
    .a_i      (op_a),
    .b_i      (op_b),
    .result_o (alu_result)
  );

`ifdef JERICALLA_SLL_EN
  assign wr_en = 1'b1;
`else
  assign wr_en = (instr.op != OP_NOP);
`endif

  always_comb begin
    dout_d = dout_q;
    zf_d   = zf_q;
    if (wr_en) begin
      dout_d = alu_result;
      zf_d   = (alu_result == '0);
    end
  end

  // NOTE: the register file is reset (RF[i] = i), so it must be built from flops;
  // a RAM macro without reset could not provide this start state.
  always_ff @(posedge clk_jericalla or negedge rst_n_jericalla) begin
    if (!rst_n_jericalla) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= DATA_W'(i);
      dout_q <= '0;
      zf_q   <= 1'b1;
    end else begin
      // NOTE: non-blocking writes mean rd==rs/rt reads see the pre-edge value.
      dout_q <= dout_d;
      zf_q   <= zf_d;
      if (wr_en) rf_q[instr.rd] <= alu_result;
    end
  end

  assign bus.dataOut_jericalla = dout_q;
  assign bus.zf_jericalla      = zf_q;

endmodule

// File: tb/tb_jericalla_evo_core.sv
// Self-checking bench: directed vector table, random ops against a reference model, async reset.
module tb_jericalla_evo_core;
  import jericalla_pkg::*;

`ifdef JERICALLA_SLL_EN
  localparam bit SLL = 1'b1;
`else
  localparam bit SLL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  jericalla_if bus();

  jericalla_evo_core dut (
    .clk_jericalla   (clk),
    .rst_n_jericalla (rst_n),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_rf [32];
  logic [31:0] m_dout;
  logic        m_zf;

  typedef struct packed {
    logic [17:0] ins;
    logic [31:0] dout;
    logic        zf;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return ~(a | b);
      3'd5:    return a ^ b;
      3'd6:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return a << sh;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'(i);
    m_dout = 32'd0;
    m_zf   = 1'b1;
  endtask

  task automatic model_exec(input logic [17:0] ins);
    logic [31:0] r;
    if (ins[17:15] == 3'b111 && !SLL) return;
    r = ref_alu(ins[17:15], m_rf[ins[14:10]], m_rf[ins[9:5]]);
    m_rf[ins[4:0]] = r;
    m_dout = r;
    m_zf   = (r == 32'd0);
  endtask

  // Apply one instruction for exactly one rising edge, sample #1 later.
  task automatic step(input logic [17:0] ins);
    bus.instruccion = ins;
    @(posedge clk);
    #1;
    model_exec(ins);
  endtask

  task automatic check_model(input string tag);
    check({tag, " dout"}, bus.dataOut_jericalla, m_dout);
    check({tag, " zf"}, {31'd0, bus.zf_jericalla}, {31'd0, m_zf});
  endtask

  // Observe RF[k] through OR k,k,k (writes the same value back).
  task automatic readback_all(input string tag);
    logic [4:0] kk;
    for (int k = 0; k < 32; k++) begin
      kk = k[4:0];
      step({3'b011, kk, kk, kk});
      check($sformatf("%s rf%0d", tag, k), bus.dataOut_jericalla, m_rf[k]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{18'b000_00100_00000_00001, 32'd4,          1'b0};
    vecs[1]  = '{18'b001_00101_00001_00010, 32'd1,          1'b0};
    vecs[2]  = '{18'b010_00110_00010_00011, 32'd0,          1'b1};
    vecs[3]  = '{18'b011_00000_00111_00100, 32'd7,          1'b0};
    vecs[4]  = '{18'b001_00000_00001_00101, 32'hFFFF_FFFC,  1'b0};
    vecs[5]  = '{18'b110_00101_00000_00110, 32'd1,          1'b0};
    vecs[6]  = '{18'b000_00001_00001_00001, 32'd8,          1'b0};
    vecs[7]  = '{18'b000_00001_00001_00001, 32'd16,         1'b0};
    vecs[8]  = '{18'b000_00001_00001_00001, 32'd32,         1'b0};
    vecs[9]  = '{18'b111_00100_00010_00111, SLL ? 32'd14 : 32'd32, 1'b0};
    vecs[10] = '{18'b100_00000_00000_01000, 32'hFFFF_FFFF,  1'b0};
    vecs[11] = '{18'b101_01001_01010_01001, 32'd3,          1'b0};
    vecs[12] = '{18'b001_01001_01001_01010, 32'd0,          1'b1};
    vecs[13] = '{18'b110_00000_00101_01011, 32'd0,          1'b1};
    vecs[14] = '{18'b111_00011_00011_01100, 32'd0,          1'b1};
    vecs[15] = '{18'b000_01000_00001_01101, 32'h0000_001F,  1'b0};

    rst_n = 1'b0;
    bus.instruccion = 18'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset dout", bus.dataOut_jericalla, 32'd0);
    check("reset zf", {31'd0, bus.zf_jericalla}, 32'd1);
    rst_n = 1'b1;

    readback_all("reset");

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].ins);
      check($sformatf("vec%0d dout", i), bus.dataOut_jericalla, vecs[i].dout);
      check($sformatf("vec%0d zf", i), {31'd0, bus.zf_jericalla}, {31'd0, vecs[i].zf});
    end

    for (int n = 0; n < 400; n++) begin
      logic [17:0] ins;
      ins = 18'($urandom);
      step(ins);
      check_model($sformatf("rand%0d", n));
    end
    readback_all("post-rand");

    // Reset asserted between edges clears outputs without a clock edge.
    step({3'b000, 5'd4, 5'd0, 5'd0});
    #3;
    rst_n = 1'b0;
    #1;
    check("async rst dout", bus.dataOut_jericalla, 32'd0);
    check("async rst zf", {31'd0, bus.zf_jericalla}, 32'd1);
    // An edge while reset is held must not write the register file.
    bus.instruccion = {3'b000, 5'd4, 5'd4, 5'd0};
    @(posedge clk);
    #1;
    check("rst hold dout", bus.dataOut_jericalla, 32'd0);
    check("rst hold zf", {31'd0, bus.zf_jericalla}, 32'd1);
    rst_n = 1'b1;
    model_reset();
    readback_all("post-rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
